// File: rtl/mts_outer_product_assembler.sv
// Assembles full FP32 outer-product rows from captured operands plus the external mantissa cross-product.
// Optional `MTS_OPA_OVF_SAT_EN: exponent overflow saturates to signed max-finite instead of signed Inf.
module mts_outer_product_assembler #(
    parameter int MAT_SIZE_1 = 16,
    parameter int MAT_SIZE_2 = 16,
    parameter int FP_EXP_W   = 8,
    parameter int FP_MANT_W  = 23,
    parameter int FP_BIAS    = 127,
    localparam int FP_W      = 1 + FP_EXP_W + FP_MANT_W,
    localparam int IDX_W     = (MAT_SIZE_1 > 1) ? $clog2(MAT_SIZE_1) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [FP_W*MAT_SIZE_1-1:0]              vec_1,
    input  logic [FP_W*MAT_SIZE_2-1:0]              vec_2,
    output logic [FP_MANT_W*MAT_SIZE_1-1:0]         cp_vec_1,
    output logic [FP_MANT_W*MAT_SIZE_2-1:0]         cp_vec_2,
    input  logic [FP_MANT_W*MAT_SIZE_1*MAT_SIZE_2-1:0] cp_mant_matrix,
    input  logic [MAT_SIZE_1*MAT_SIZE_2-1:0]        cp_bump_matrix,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [FP_W*MAT_SIZE_2-1:0]              out_row,
    output logic [IDX_W-1:0]                        out_row_idx,
    output logic                                    out_last
);

    localparam int EW = FP_EXP_W + 3;
    localparam logic signed [EW-1:0] BIAS_S   = EW'(FP_BIAS);
    localparam logic signed [EW-1:0] EXP_TOP  = EW'((1 << FP_EXP_W) - 1);
    localparam logic [IDX_W-1:0]     LAST_ROW = IDX_W'(MAT_SIZE_1 - 1);
    localparam logic [IDX_W-1:0]     ONE      = IDX_W'(1);
    localparam logic [FP_W-1:0]      QNAN     = {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MANT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       row_ctr;
    logic [IDX_W-1:0]       sel;
    logic [FP_W*MAT_SIZE_2-1:0] next_row;

    logic                   cap_sign_1 [MAT_SIZE_1];
    logic [FP_EXP_W-1:0]    cap_exp_1  [MAT_SIZE_1];
    logic [FP_MANT_W-1:0]   cap_frac_1 [MAT_SIZE_1];
    logic                   cap_sign_2 [MAT_SIZE_2];
    logic [FP_EXP_W-1:0]    cap_exp_2  [MAT_SIZE_2];
    logic [FP_MANT_W-1:0]   cap_frac_2 [MAT_SIZE_2];

    // Special-case precedence: NaN/Inf*0, Inf, zero operand, overflow, underflow, normal.
    function automatic logic [FP_W-1:0] build_elem(
        input logic                 s1,
        input logic [FP_EXP_W-1:0]  e1,
        input logic [FP_MANT_W-1:0] f1,
        input logic                 s2,
        input logic [FP_EXP_W-1:0]  e2,
        input logic [FP_MANT_W-1:0] f2,
        input logic [FP_MANT_W-1:0] mant,
        input logic                 bump
    );
        logic                  sign;
        logic                  nan_1, nan_2, inf_1, inf_2, zero_1, zero_2;
        logic signed [EW-1:0]  e;
        logic [FP_W-1:0]       ovf;
        logic [FP_W-1:0]       r;
        sign   = s1 ^ s2;
        nan_1  = (&e1) && (|f1);
        nan_2  = (&e2) && (|f2);
        inf_1  = (&e1) && !(|f1);
        inf_2  = (&e2) && !(|f2);
        zero_1 = ~|e1;
        zero_2 = ~|e2;
        e = $signed({3'b000, e1}) + $signed({3'b000, e2}) - BIAS_S
            + $signed({{(EW-1){1'b0}}, bump});
`ifdef MTS_OPA_OVF_SAT_EN
        ovf = {sign, {(FP_EXP_W-1){1'b1}}, 1'b0, {FP_MANT_W{1'b1}}};
`else
        ovf = {sign, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
`endif
        if (nan_1 || nan_2 || (inf_1 && zero_2) || (inf_2 && zero_1))
            r = QNAN;
        else if (inf_1 || inf_2)
            r = {sign, {FP_EXP_W{1'b1}}, {FP_MANT_W{1'b0}}};
        else if (zero_1 || zero_2)
            r = {sign, {(FP_W-1){1'b0}}};
        else if (e >= EXP_TOP)
            r = ovf;
        else if (e[EW-1] || (e == '0))
            r = {sign, {(FP_W-1){1'b0}}};
        else
            r = {sign, e[FP_EXP_W-1:0], mant};
        return r;
    endfunction

    // In EMIT the row being built is the one after the row currently presented.
    assign sel = (state == EMIT) ? row_ctr + ONE : row_ctr;

    always_comb begin
        next_row = '0;
        for (int j = 0; j < MAT_SIZE_2; j++) begin
            next_row[j*FP_W +: FP_W] = build_elem(
                cap_sign_1[sel], cap_exp_1[sel], cap_frac_1[sel],
                cap_sign_2[j],   cap_exp_2[j],   cap_frac_2[j],
                cp_mant_matrix[(int'(sel)*MAT_SIZE_2 + j)*FP_MANT_W +: FP_MANT_W],
                cp_bump_matrix[int'(sel)*MAT_SIZE_2 + j]);
        end
    end

    always_comb begin
        cp_vec_1 = '0;
        for (int k = 0; k < MAT_SIZE_1; k++)
            cp_vec_1[k*FP_MANT_W +: FP_MANT_W] = cap_frac_1[k];
    end

    always_comb begin
        cp_vec_2 = '0;
        for (int k = 0; k < MAT_SIZE_2; k++)
            cp_vec_2[k*FP_MANT_W +: FP_MANT_W] = cap_frac_2[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
            out_last    <= 1'b0;
            row_ctr     <= '0;
            for (int k = 0; k < MAT_SIZE_1; k++) begin
                cap_sign_1[k] <= 1'b0;
                cap_exp_1[k]  <= '0;
                cap_frac_1[k] <= '0;
            end
            for (int k = 0; k < MAT_SIZE_2; k++) begin
                cap_sign_2[k] <= 1'b0;
                cap_exp_2[k]  <= '0;
                cap_frac_2[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < MAT_SIZE_1; k++) begin
                            cap_sign_1[k] <= vec_1[k*FP_W + FP_W - 1];
                            cap_exp_1[k]  <= vec_1[k*FP_W + FP_MANT_W +: FP_EXP_W];
                            cap_frac_1[k] <= vec_1[k*FP_W +: FP_MANT_W];
                        end
                        for (int k = 0; k < MAT_SIZE_2; k++) begin
                            cap_sign_2[k] <= vec_2[k*FP_W + FP_W - 1];
                            cap_exp_2[k]  <= vec_2[k*FP_W + FP_MANT_W +: FP_EXP_W];
                            cap_frac_2[k] <= vec_2[k*FP_W +: FP_MANT_W];
                        end
                        row_ctr  <= '0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    out_row     <= next_row;
                    out_row_idx <= row_ctr;
                    out_last    <= (row_ctr == LAST_ROW);
                    out_valid   <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (row_ctr != LAST_ROW) begin
                            row_ctr     <= sel;
                            out_row     <= next_row;
                            out_row_idx <= sel;
                            out_last    <= (sel == LAST_ROW);
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mts_outer_product_assembler.sv
// Directed bench for mts_outer_product_assembler with a behavioural mantissa cross-product model.
module tb_mts_outer_product_assembler;

    localparam int N1 = 16;
    localparam int N2 = 16;
    localparam int W  = 32;
    localparam int MW = 23;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [W*N1-1:0]       vec_1;
    logic [W*N2-1:0]       vec_2;
    logic [MW*N1-1:0]      cp_vec_1;
    logic [MW*N2-1:0]      cp_vec_2;
    logic [MW*N1*N2-1:0]   cp_mant_matrix;
    logic [N1*N2-1:0]      cp_bump_matrix;
    logic                  out_valid;
    logic                  out_ready;
    logic [W*N2-1:0]       out_row;
    logic [3:0]            out_row_idx;
    logic                  out_last;

    int n_checks = 0;
    int n_pass   = 0;

    int          cell_i [$];
    int          cell_j [$];
    logic [31:0] cell_v [$];

`ifdef MTS_OPA_OVF_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7F7FFFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h7F800000;
`endif

    always #5 clk = ~clk;

    mts_outer_product_assembler dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .vec_1          (vec_1),
        .vec_2          (vec_2),
        .cp_vec_1       (cp_vec_1),
        .cp_vec_2       (cp_vec_2),
        .cp_mant_matrix (cp_mant_matrix),
        .cp_bump_matrix (cp_bump_matrix),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .out_row_idx    (out_row_idx),
        .out_last       (out_last)
    );

    // Cross-product stand-in: (1.f1)*(1.f2), normalised and truncated.
    logic [47:0] prod;
    always_comb begin
        cp_mant_matrix = '0;
        cp_bump_matrix = '0;
        prod = '0;
        for (int i = 0; i < N1; i++) begin
            for (int j = 0; j < N2; j++) begin
                prod = {1'b1, cp_vec_1[i*MW +: MW]} * {1'b1, cp_vec_2[j*MW +: MW]};
                cp_bump_matrix[i*N2 + j] = prod[47];
                cp_mant_matrix[(i*N2 + j)*MW +: MW] = prod[47] ? prod[46:24] : prod[45:23];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic add_cell(input int i, input int j, input logic [31:0] v);
        cell_i.push_back(i);
        cell_j.push_back(j);
        cell_v.push_back(v);
    endtask

    task automatic set_elem_1(input int k, input logic [31:0] v);
        vec_1[k*W +: W] = v;
    endtask

    task automatic set_elem_2(input int k, input logic [31:0] v);
        vec_2[k*W +: W] = v;
    endtask

    // Operand set A covers the arithmetic and special-value corners; B differs only in vec_2[0].
    task automatic load_set(input bit set_b);
        for (int k = 0; k < N1; k++) set_elem_1(k, 32'h3F800000);
        for (int k = 0; k < N2; k++) set_elem_2(k, 32'h3F800000);
        set_elem_1(1, 32'h3FC00000);
        set_elem_1(3, 32'h7F000000);
        set_elem_1(4, 32'h00800000);
        set_elem_1(5, 32'h80000000);
        set_elem_1(6, 32'h00000000);
        set_elem_1(7, 32'h7FC00001);
        set_elem_1(8, 32'hFF800000);
        set_elem_2(0, set_b ? 32'h40400000 : 32'h40000000);
        set_elem_2(1, 32'hBFC00000);
        set_elem_2(3, 32'h7F000000);
        set_elem_2(4, 32'h00800000);
        set_elem_2(6, 32'h7F800000);
        cell_i.delete();
        cell_j.delete();
        cell_v.delete();
        if (!set_b) begin
            add_cell(0, 0, 32'h40000000);
            add_cell(0, 1, 32'hBFC00000);
            add_cell(0, 2, 32'h3F800000);
            add_cell(1, 0, 32'h40400000);
            add_cell(1, 1, 32'hC0100000);
            add_cell(2, 0, 32'h40000000);
            add_cell(3, 3, OVF_POS);
            add_cell(4, 4, 32'h00000000);
            add_cell(5, 2, 32'h80000000);
            add_cell(6, 6, 32'h7FC00000);
            add_cell(7, 2, 32'h7FC00000);
            add_cell(8, 0, 32'hFF800000);
            add_cell(8, 6, 32'hFF800000);
            add_cell(12, 5, 32'h3F800000);
            add_cell(15, 0, 32'h40000000);
        end else begin
            add_cell(0, 0, 32'h40400000);
            add_cell(0, 2, 32'h3F800000);
            add_cell(1, 0, 32'h40900000);
            add_cell(15, 0, 32'h40400000);
        end
    endtask

    task automatic check_cells(input int r);
        for (int c = 0; c < cell_i.size(); c++)
            if (cell_i[c] == r)
                check_eq($sformatf("cell_%0d_%0d", r, cell_j[c]), out_row[cell_j[c]*W +: W], cell_v[c]);
    endtask

    // Entered at a negedge with the DUT idle; leaves at the negedge where row 0 is presented.
    task automatic start_job();
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vec_1 = '1;
        vec_2 = '1;
        check_eq("load_out_valid", 32'(out_valid), 32'd0);
        check_eq("load_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int abort_row, input int stall_row);
        bit aborted;
        aborted = 1'b0;
        for (int r = 0; r < N1; r++) begin
            check_eq($sformatf("row%0d_valid", r), 32'(out_valid), 32'd1);
            check_eq($sformatf("row%0d_idx", r), 32'(out_row_idx), 32'(r));
            check_eq($sformatf("row%0d_last", r), 32'(out_last), 32'(r == N1 - 1));
            check_eq($sformatf("row%0d_in_ready", r), 32'(in_ready), 32'd0);
            check_cells(r);
            if (r == abort_row) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (r == stall_row) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    @(negedge clk);
                    check_eq("stall_valid", 32'(out_valid), 32'd1);
                    check_eq("stall_idx", 32'(out_row_idx), 32'(r));
                    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                    check_cells(r);
                end
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check_eq(aborted ? "abort_out_valid" : "done_out_valid", 32'(out_valid), 32'd0);
        check_eq(aborted ? "abort_in_ready" : "done_in_ready", 32'(in_ready), 32'd1);
        check_eq(aborted ? "abort_out_last" : "done_out_last", 32'(out_last), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vec_1     = '0;
        vec_2     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_idx", 32'(out_row_idx), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_out_row_zero", 32'(out_row == '0), 32'd1);
        check_eq("rst_cp_vec_zero", 32'((cp_vec_1 == '0) && (cp_vec_2 == '0)), 32'd1);

        // Full-throughput job.
        load_set(1'b0);
        start_job();
        drain(-1, -1);

        // Backpressure on row 2 with a spurious in_valid pulse.
        load_set(1'b0);
        start_job();
        drain(-1, 2);

        // Reset mid-job at row 5, then a fresh job with different operands.
        load_set(1'b0);
        start_job();
        drain(5, -1);
        load_set(1'b1);
        start_job();
        drain(-1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
